// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Multi-channel programmable rate divider. Each channel counts
//            down from a runtime-loadable divisor D and emits a single-cycle
//            tick every D+1 enabled cycles, plus a level output that toggles
//            on every tick. A common sync strobe restarts all channels in
//            phase.
// Options  : TICK_GEN_ONESHOT_EN adds a per-channel oneshot input. A channel
//            in oneshot mode ticks once, then parks at zero until it is
//            reloaded, synced, or has its oneshot bit cleared.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 13,
    parameter int DEFAULT_DIV = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                sync,
    input  logic                load,
    input  logic [2:0]          load_ch,
    input  logic [DIV_W-1:0]    load_val,
`ifdef TICK_GEN_ONESHOT_EN
    input  logic [CHANNELS-1:0] oneshot,
`endif
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level
);

    localparam logic [DIV_W-1:0] c_default_div = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_one         = DIV_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_level;
        logic             w_load_hit;

        // Channel indices never exceed 7, so a 3-bit compare rejects any
        // load aimed past the last channel without extra range logic.
        assign w_load_hit = load && (load_ch == 3'(i));

`ifdef TICK_GEN_ONESHOT_EN
        logic r_parked;

        // Down-counter with load/sync priority; oneshot channels stop at zero
        // after their tick and stay parked until re-armed.
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_div    <= c_default_div;
                r_cnt    <= c_default_div;
                r_tick   <= 1'b0;
                r_level  <= 1'b0;
                r_parked <= 1'b0;
            end else if (w_load_hit) begin
                r_div    <= load_val;
                r_cnt    <= load_val;
                r_tick   <= 1'b0;
                r_parked <= 1'b0;
                if (sync) begin
                    r_level <= 1'b0;
                end
            end else if (sync) begin
                r_cnt    <= r_div;
                r_tick   <= 1'b0;
                r_level  <= 1'b0;
                r_parked <= 1'b0;
            end else if (!enable) begin
                r_tick <= 1'b0;
            end else if (r_cnt == '0) begin
                if (oneshot[i] && r_parked) begin
                    r_tick <= 1'b0;
                end else begin
                    r_cnt    <= oneshot[i] ? '0 : r_div;
                    r_tick   <= 1'b1;
                    r_level  <= ~r_level;
                    r_parked <= oneshot[i];
                end
            end else begin
                r_cnt  <= r_cnt - c_one;
                r_tick <= 1'b0;
            end
        end
`else
        // Down-counter with load/sync priority; reload and tick on reaching 0.
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_div   <= c_default_div;
                r_cnt   <= c_default_div;
                r_tick  <= 1'b0;
                r_level <= 1'b0;
            end else if (w_load_hit) begin
                r_div  <= load_val;
                r_cnt  <= load_val;
                r_tick <= 1'b0;
                if (sync) begin
                    r_level <= 1'b0;
                end
            end else if (sync) begin
                r_cnt   <= r_div;
                r_tick  <= 1'b0;
                r_level <= 1'b0;
            end else if (!enable) begin
                r_tick <= 1'b0;
            end else if (r_cnt == '0) begin
                r_cnt   <= r_div;
                r_tick  <= 1'b1;
                r_level <= ~r_level;
            end else begin
                r_cnt  <= r_cnt - c_one;
                r_tick <= 1'b0;
            end
        end
`endif

        assign tick[i]  = r_tick;
        assign level[i] = r_level;
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_gen
// Purpose  : Directed-vector bench for tick_gen with the default two
//            channels: reset values, default-divisor period, loads, sync,
//            enable gaps, load-on-expiry, sync with load, reset discarding
//            strobes, and oneshot parking when that option is built in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        sync;
    logic        load;
    logic [2:0]  load_ch;
    logic [12:0] load_val;
    logic [1:0]  tick;
    logic [1:0]  level;
`ifdef TICK_GEN_ONESHOT_EN
    logic [1:0]  oneshot;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic        sy;
        logic        ld;
        logic [2:0]  ch;
        logic [12:0] val;
        logic [1:0]  et;
        logic [1:0]  el;
    } vec_t;

    vec_t vecs[$];

    tick_gen dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
`ifdef TICK_GEN_ONESHOT_EN
        .oneshot  (oneshot),
`endif
        .tick     (tick),
        .level    (level)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] et, input logic [1:0] el);
        checks++;
        if (tick !== et || level !== el) begin
            failures++;
            $display("FAIL %s: tick=%b want %b, level=%b want %b", name, tick, et, level, el);
        end
    endtask

    task automatic check1(input string name, input logic et);
        checks++;
        if (tick[0] !== et) begin
            failures++;
            $display("FAIL %s: tick[0]=%b want %b", name, tick[0], et);
        end
    endtask

    task automatic add(input logic en, input logic sy, input logic ld, input logic [2:0] ch,
                       input logic [12:0] val, input logic [1:0] et, input logic [1:0] el);
        vec_t v;
        v.en = en; v.sy = sy; v.ld = ld; v.ch = ch; v.val = val; v.et = et; v.el = el;
        vecs.push_back(v);
    endtask

    task automatic idle();
        sync = 1'b0; load = 1'b0; load_ch = 3'd0; load_val = 13'd0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        idle();
`ifdef TICK_GEN_ONESHOT_EN
        oneshot = 2'b00;
`endif

        // ---------------- vector table ----------------
        // load ch0=3: tick[0] every 4 cycles, ch1 keeps counting
        add(1,0,1,0,13'd3, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b01,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b01,2'b00);
        // load ch1=0: tick[1] every cycle
        add(1,0,1,1,13'd0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b10,2'b10);
        add(1,0,0,0,0, 2'b10,2'b00);
        add(1,0,0,0,0, 2'b11,2'b11);
        // out-of-range channel load is ignored
        add(1,0,1,5,13'd7, 2'b10,2'b01);
        add(1,0,0,0,0, 2'b10,2'b11);
        add(1,0,0,0,0, 2'b10,2'b01);
        add(1,0,0,0,0, 2'b11,2'b10);
        // ch1=5 then sync: ticks at +4, +6, coincident at +12
        add(1,0,1,1,13'd5, 2'b00,2'b10);
        add(1,1,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b01,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b10,2'b11);
        add(1,0,0,0,0, 2'b00,2'b11);
        add(1,0,0,0,0, 2'b01,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b11,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);   // cnt0=2, cnt1=4
        // enable low for 10 cycles: everything holds
        for (int k = 0; k < 10; k++) add(0,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b01,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b10,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);   // cnt0 reaches 0
        // load on the expiry cycle suppresses the tick
        add(1,0,1,0,13'd2, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b00,2'b10);
        add(1,0,0,0,0, 2'b01,2'b11);
        add(1,0,0,0,0, 2'b10,2'b01);
        // sync together with load ch0=1
        add(1,1,1,0,13'd1, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b01,2'b01);
        add(1,0,0,0,0, 2'b00,2'b01);
        add(1,0,0,0,0, 2'b01,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b11,2'b11);
        // sync still honoured while disabled
        add(0,1,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b00,2'b00);
        add(1,0,0,0,0, 2'b01,2'b01);

        // ---------------- reset and default divisor ----------------
        step();
        step();
        check("reset", 2'b00, 2'b00);
        reset = 1'b1; enable = 1'b1;
        for (int c = 1; c <= 512; c++) begin
            step();
            check("default_div", (c % 256 == 0) ? 2'b11 : 2'b00,
                  (c >= 256 && c < 512) ? 2'b11 : 2'b00);
        end

        // ---------------- table ----------------
        for (int n = 0; n < vecs.size(); n++) begin
            enable   = vecs[n].en;
            sync     = vecs[n].sy;
            load     = vecs[n].ld;
            load_ch  = vecs[n].ch;
            load_val = vecs[n].val;
            step();
            check($sformatf("vec[%0d]", n), vecs[n].et, vecs[n].el);
        end
        idle();

`ifdef TICK_GEN_ONESHOT_EN
        // ---------------- oneshot ----------------
        reset = 1'b0; step(); reset = 1'b1;
        oneshot = 2'b01; enable = 1'b1;
        load = 1'b1; load_ch = 3'd0; load_val = 13'd4;
        step();
        idle();
        check1("os_load", 1'b0);
        for (int c = 1; c <= 55; c++) begin
            step();
            check1("os_single", c == 5);
        end
        load = 1'b1; load_ch = 3'd0; load_val = 13'd4;
        step();
        idle();
        for (int c = 1; c <= 8; c++) begin
            step();
            check1("os_rearm", c == 5);
        end
        oneshot = 2'b00;
        step();
        check1("os_resume", 1'b1);
`endif

        // ---------------- reset discards same-cycle load/sync ----------------
        reset = 1'b0; enable = 1'b1; sync = 1'b1;
        load = 1'b1; load_ch = 3'd0; load_val = 13'd0;
        step();
        check("reset_mid", 2'b00, 2'b00);
        reset = 1'b1;
        idle();
        for (int c = 1; c <= 256; c++) begin
            step();
            check("after_reset", (c == 256) ? 2'b11 : 2'b00, (c == 256) ? 2'b11 : 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Multi-channel programmable rate divider. Generates periodic single-cycle tick strobes and 50%-duty toggle levels from the system clock.
- Replaces the fixed-divisor game-clock divider.
- Sits between CLOCK_50 and the game FSM, cursor-blink logic and random-source stepping, each on its own channel.
- Divisors are runtime-loadable; channels can be phase-aligned with a common sync.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..8).
- DIV_W, 13, width of each divisor and down-counter.
- DEFAULT_DIV, 255, divisor value loaded into every channel at reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global run; 0 freezes all counters.
- sync  in  1  one-cycle strobe; restarts all channels in phase.
- load  in  1  one-cycle strobe; write load_val into channel load_ch.
- load_ch  in  3  target channel index for load.
- load_val  in  DIV_W  new divisor.
- tick  out  CHANNELS  per-channel single-cycle strobe, registered.
- level  out  CHANNELS  per-channel square wave, toggles on each tick, registered.

Behaviour:
- Reset (reset==0 at posedge):
  - div_reg[i]=DEFAULT_DIV, cnt[i]=DEFAULT_DIV, tick=0, level=0.
  - Reset mid-operation discards any load or sync in that cycle.
- Per channel i with enable=1:
  - If cnt[i]==0: cnt[i]<=div_reg[i], tick[i]<=1, level[i]<=~level[i].
  - Else: cnt[i]<=cnt[i]-1, tick[i]<=0.
- Period:
  - Divisor D gives tick every D+1 cycles; level period is 2(D+1).
  - D=0 gives tick=1 every cycle and level toggling every cycle.
- Counter is unsigned DIV_W bits, down-counting only. No wrap below 0 (reload at 0).
- enable=0:
  - cnt and level hold; tick forced 0 next cycle.
  - load and sync are still honoured.
- load=1:
  - If load_ch<CHANNELS: div_reg[load_ch]<=load_val, cnt[load_ch]<=load_val, tick[load_ch]<=0, level unchanged.
  - If load_ch>=CHANNELS: no effect.
  - Load overrides expiry on the same channel in the same cycle, so that expiry produces no tick.
- sync=1:
  - All channels: cnt[i]<=div_reg[i], level[i]<=0, tick[i]<=0.
  - Priority over expiry.
- Simultaneous load and sync:
  - Loaded channel takes cnt=load_val and div_reg=load_val, level=0.
  - Other channels follow the sync rule.
- First tick after reset or sync arrives D+1 cycles later, assuming enable is held high.
- Outputs come straight from registers; no combinational path from inputs to tick or level.

Optional Feature:
- Macro: TICK_GEN_ONESHOT_EN.
- With the macro defined:
  - Extra input port oneshot, width CHANNELS.
  - A channel with oneshot[i]=1 emits one tick, then parks: cnt holds at 0, no further ticks, level holds.
  - A load to that channel or a sync re-arms it.
  - Clearing oneshot[i] while parked resumes periodic operation. The next cycle at 0 ticks immediately.
- Without the macro: the oneshot port is absent and all channels are always periodic.

Test Plan:
- Reset, then enable=1, default divisor 255 → tick[0] and tick[1] high on cycle 256 and every 256 cycles after; level toggles at the same instants.
- load ch0=3 while ch1 stays at 255 → tick[0] every 4 cycles starting 4 cycles after load; tick[1] is undisturbed.
- load ch1=0 → tick[1] high every cycle and level[1] toggles every cycle; then load_ch=5 with CHANNELS=2 → no state change.
- Run ch0=3 and ch1=5, assert sync → both levels 0; next ticks at +4 and +6 cycles; coincident ticks at +12 cycles.
- Drop enable for 10 cycles mid-count with cnt[0]=2 → no ticks during the gap; after re-enable, first tick comes 3 cycles later. Separately, load on the exact expiry cycle → no tick that cycle.
- With TICK_GEN_ONESHOT_EN, oneshot[0]=1, div=4 → exactly one tick at cycle 5 then none for 50 cycles; load ch0=4 → another single tick 5 cycles later.
